// File: rtl/q_sys_pll_pkg.sv
// Shared types and helpers for the q_sys PLL lock sequencer.
package q_sys_pll_pkg;

  typedef enum logic [2:0] {
    StPllRst,
    StWaitLock,
    StStable,
    StRun,
    StLost
  } pll_state_e;

  // One timer serves every state, so it is sized for the longest interval.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/q_sys_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level signal; resets to 0.
module q_sys_bit_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/q_sys_pll_lock_sequencer.sv
// Pulses PLL reset, waits for a stable synchronised lock, then releases system reset;
// retries on timeout and re-initialises on lock loss, counting losses.
module q_sys_pll_lock_sequencer
  import q_sys_pll_pkg::*;
#(
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 100000,
  parameter int unsigned STABLE_CYC       = 1024,
  parameter int unsigned CNT_W            = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_pll_locked,
  output logic             o_pll_rst,
  output logic             o_sys_reset_n,
  output logic             o_lock_ok,
  output logic [CNT_W-1:0] o_lost_cnt,
  input  logic             i_clr_cnt
);

  localparam int unsigned TimerW = timer_width(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC);
  localparam logic [TimerW-1:0] RstLast     = TimerW'(RST_PULSE_CYC - 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [TimerW-1:0] StableLast  = TimerW'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0]  CntMax      = '1;

  pll_state_e        r_state;
  logic [TimerW-1:0] r_timer;
  logic              r_pll_rst;
  logic              r_sys_reset_n;
  logic              r_lock_ok;
  logic [CNT_W-1:0]  r_lost_cnt;
  logic              w_lk_s;
  logic              w_loss;

  q_sys_bit_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (i_pll_locked),
    .o_q       (w_lk_s)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= StPllRst;
      r_timer       <= '0;
      r_pll_rst     <= 1'b1;
      r_sys_reset_n <= 1'b0;
      r_lock_ok     <= 1'b0;
    end else begin
      unique case (r_state)
        StPllRst: begin
          if (r_timer == RstLast) begin
            r_timer   <= '0;
            r_pll_rst <= 1'b0;
            r_state   <= StWaitLock;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        StWaitLock: begin
          if (w_lk_s) begin
            r_timer <= '0;
            r_state <= StStable;
          end else if (r_timer == TimeoutLast) begin
            r_timer   <= '0;
            r_pll_rst <= 1'b1;
            r_state   <= StPllRst;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        StStable: begin
          // Any dropout sends us back to wait, so the count is strictly consecutive.
          if (!w_lk_s) begin
            r_timer <= '0;
            r_state <= StWaitLock;
          end else if (r_timer == StableLast) begin
            r_timer       <= '0;
            r_sys_reset_n <= 1'b1;
            r_lock_ok     <= 1'b1;
            r_state       <= StRun;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        StRun: begin
          if (!w_lk_s) begin
            r_sys_reset_n <= 1'b0;
            r_lock_ok     <= 1'b0;
            r_state       <= StLost;
          end
        end
        StLost: begin
          r_timer   <= '0;
          r_pll_rst <= 1'b1;
          r_state   <= StPllRst;
        end
        default: begin
          r_timer       <= '0;
          r_pll_rst     <= 1'b1;
          r_sys_reset_n <= 1'b0;
          r_lock_ok     <= 1'b0;
          r_state       <= StPllRst;
        end
      endcase
    end
  end

  // The loss event is the RUN cycle that sees lock drop; a clear in that cycle wins.
  assign w_loss = (r_state == StRun) && !w_lk_s;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_lost_cnt <= '0;
    end else if (i_clr_cnt) begin
      r_lost_cnt <= '0;
    end else if (w_loss && (r_lost_cnt != CntMax)) begin
      r_lost_cnt <= r_lost_cnt + 1'b1;
    end
  end

  assign o_pll_rst     = r_pll_rst;
  assign o_sys_reset_n = r_sys_reset_n;
  assign o_lock_ok     = r_lock_ok;
  assign o_lost_cnt    = r_lost_cnt;

endmodule

// File: tb/tb_q_sys_pll_lock_sequencer.sv
// Directed bench for the PLL lock sequencer: expectations are queued as stimulus is
// applied and popped when the matching DUT response is measured.
module tb_q_sys_pll_lock_sequencer;

  localparam int unsigned CntW = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            pll_locked;
  logic            clr_cnt;
  logic            pll_rst;
  logic            sys_reset_n;
  logic            lock_ok;
  logic [CntW-1:0] lost_cnt;

  int          n_vec  = 0;
  int          n_miss = 0;
  int          n;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  q_sys_pll_lock_sequencer #(
    .SYNC_STAGES      (2),
    .RST_PULSE_CYC    (16),
    .LOCK_TIMEOUT_CYC (200),
    .STABLE_CYC       (1024),
    .CNT_W            (CntW)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_pll_locked  (pll_locked),
    .o_pll_rst     (pll_rst),
    .o_sys_reset_n (sys_reset_n),
    .o_lock_ok     (lock_ok),
    .o_lost_cnt    (lost_cnt),
    .i_clr_cnt     (clr_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic check(input logic [31:0] obs);
    string       tag;
    logic [31:0] want;
    tag  = tag_q.pop_front();
    want = exp_q.pop_front();
    n_vec++;
    assert (obs === want) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // Cycles until sys_reset_n reaches val; limit+1 means it never did.
  task automatic until_sys(input logic val, input int limit, output int cnt);
    cnt = 0;
    while (sys_reset_n !== val && cnt <= limit) begin
      tick();
      cnt++;
    end
  endtask

  task automatic until_rst(input logic val, input int limit, output int cnt);
    cnt = 0;
    while (pll_rst !== val && cnt <= limit) begin
      tick();
      cnt++;
    end
  endtask

  // From RUN: lose lock, check the count, relock. The raise lands two cycles after LOST
  // is seen, leaving 15 pulse cycles + 1 WAIT_LOCK cycle + 1024 stable cycles = 1040.
  task automatic lose_and_relock(input int cnt_want);
    int c;
    pll_locked = 1'b0;
    push_exp("loss_latency", 3);
    until_sys(1'b0, 20, c);
    check(c);
    push_exp("lock_ok_on_loss", 0);
    check({31'd0, lock_ok});
    tick();
    tick();
    push_exp("lost_cnt", cnt_want);
    check({30'd0, lost_cnt});
    pll_locked = 1'b1;
    push_exp("relock_latency", 1040);
    until_sys(1'b1, 2000, c);
    check(c);
  endtask

  initial begin
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    clr_cnt    = 1'b0;
    repeat (3) tick();
    push_exp("reset_pll_rst", 1);     check({31'd0, pll_rst});
    push_exp("reset_sys_reset_n", 0); check({31'd0, sys_reset_n});
    push_exp("reset_lock_ok", 0);     check({31'd0, lock_ok});
    push_exp("reset_lost_cnt", 0);    check({30'd0, lost_cnt});

    // Never locked: 16-cycle pulse, 200-cycle wait, another 16-cycle pulse.
    reset_n = 1'b1;
    push_exp("first_pulse_len", 16);
    until_rst(1'b0, 100, n);
    check(n);
    push_exp("timeout_gap", 200);
    until_rst(1'b1, 400, n);
    check(n);
    push_exp("retry_pulse_len", 16);
    until_rst(1'b0, 100, n);
    check(n);
    push_exp("lost_cnt_after_timeout", 0); check({30'd0, lost_cnt});
    push_exp("sys_low_while_retrying", 0); check({31'd0, sys_reset_n});

    // Lock 50 cycles into WAIT_LOCK: release after 2 sync + 1 entry + 1024 stable cycles.
    repeat (50) tick();
    pll_locked = 1'b1;
    push_exp("release_latency", 1027);
    until_sys(1'b1, 2000, n);
    check(n);
    push_exp("lock_ok_in_run", 1);  check({31'd0, lock_ok});
    push_exp("pll_rst_in_run", 0);  check({31'd0, pll_rst});

    // First loss, then a fresh PLL reset pulse one cycle after LOST.
    pll_locked = 1'b0;
    push_exp("loss_latency", 3);
    until_sys(1'b0, 20, n);
    check(n);
    push_exp("lost_cnt_first", 1); check({30'd0, lost_cnt});
    push_exp("repulse_delay", 1);
    until_rst(1'b1, 20, n);
    check(n);
    push_exp("repulse_len", 16);
    until_rst(1'b0, 100, n);
    check(n);

    // One-cycle dropout around stable count 500 restarts the count.
    pll_locked = 1'b1;
    repeat (503) tick();
    push_exp("no_release_before_glitch", 0); check({31'd0, sys_reset_n});
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    push_exp("release_after_glitch", 1027);
    until_sys(1'b1, 2000, n);
    check(n);

    lose_and_relock(2);
    lose_and_relock(3);
    lose_and_relock(3);

    // Clear coincides with the RUN cycle that sees lock drop.
    pll_locked = 1'b0;
    tick();
    tick();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    push_exp("sys_low_on_clr_loss", 0); check({31'd0, sys_reset_n});
    push_exp("clr_wins_over_loss", 0);  check({30'd0, lost_cnt});
    tick();
    tick();
    push_exp("lost_cnt_stays_clear", 0); check({30'd0, lost_cnt});
    pll_locked = 1'b1;
    push_exp("relock_after_clr", 1040);
    until_sys(1'b1, 2000, n);
    check(n);

    lose_and_relock(1);

    // Asynchronous reset mid-cycle while in RUN.
    #2;
    reset_n = 1'b0;
    #1;
    push_exp("async_rst_pll_rst", 1);  check({31'd0, pll_rst});
    push_exp("async_rst_sys", 0);      check({31'd0, sys_reset_n});
    push_exp("async_rst_lock_ok", 0);  check({31'd0, lock_ok});
    push_exp("async_rst_lost_cnt", 0); check({30'd0, lost_cnt});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
